// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_addsub_fa.sv
// One-bit full adder assembled from two half-adder stages; the only
// arithmetic cell in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign ha1_c = ha0_s & c;
    assign sum   = ha0_s ^ c;
    assign carry = ha0_c | ha1_c;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a carry flop
// consume one operand bit per clock, LSB first, with a start/busy/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_shift;

    fa_cell u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (fa_s),
        .carry (fa_co)
    );

    // Partial result with the new bit at the MSB; on the last step this is the full sum.
    assign s_shift = {fa_s, s_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                s_d     = s_shift[WIDTH-1:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    sum_d   = s_shift;
                    cout_d  = fa_co;
                    ovf_d   = fa_co ^ carry_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8): expected results are queued
// when an operation is issued and compared when done pulses.
module tb_serial_addsub;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Reference: whole-word arithmetic; carry into MSB from a (W-1)-bit add.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tc, input logic ts);
        exp_t         e;
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb     = ts ? ~tb_ : tb_;
        c      = ts ? 1'b1 : tc;
        full   = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, c};
        low    = {1'b0, ta[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = full[W] ^ low[W-1];
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        sb.push_back(model(ta, tb_, tc, ts));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts negedges since start was driven.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [W-1:0] ta[5] = '{8'h3C, 8'hFF, 8'hFF, 8'h7F, 8'hA5};
        logic [W-1:0] tbv[5] = '{8'h55, 8'h01, 8'h01, 8'h01, 8'h9C};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tbv[i], tc[i], 1'b0);
            wait_done(1, lat, bcnt);
            n_cmp++;
            if (lat != 9 || bcnt != 8) begin
                n_bad++;
                $display("FAIL add_timing[%0d]: got latency=%0d busy_cycles=%0d, want 9 and 8", i, lat, bcnt);
            end
            if (done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL add_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             i, sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
                $display("add %h+%h+%b -> sum=%h cout=%b ovf=%b", ta[i], tbv[i], tc[i], sum, cout, ovf);
            end else begin
                n_bad++;
                $display("FAIL add_done[%0d]: no done within bound (queue=%0d)", i, sb.size());
                sb.delete();
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL add_done_pulse[%0d]: got done=%b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] ta[4] = '{8'h10, 8'h80, 8'h10, 8'h80};
        logic [W-1:0] tbv[4] = '{8'h20, 8'h01, 8'h20, 8'h01};
        logic         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tbv[i], tc[i], 1'b1);
            wait_done(1, lat, bcnt);
            if (done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL sub_result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             i, sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
                $display("sub %h-%h (cin=%b) -> sum=%h cout=%b ovf=%b", ta[i], tbv[i], tc[i], sum, cout, ovf);
            end else begin
                n_bad++;
                $display("FAIL sub_done[%0d]: no done within bound", i);
                sb.delete();
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat, bcnt;
        exp_t e;
        logic [W-1:0] prev;
        prev = sum;
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (sum !== prev) begin
            n_bad++;
            $display("FAIL ignore_mid_sum: got sum=%h mid-run, want held %h", sum, prev);
        end
        wait_done(4, lat, bcnt);
        n_cmp++;
        if (lat != 9) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d, want 9", lat);
        end
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                n_bad++;
                $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            $display("add 12+34 with ignored start -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
        end else begin
            n_bad++;
            $display("FAIL ignore_done: no done within bound");
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_single_done: got done=%b busy=%b afterwards, want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt;
        bit saw_done;
        exp_t e;
        issue(8'h3C, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        sb.delete();
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL reset_no_done: got a done pulse after abort, want none");
        end
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(1, lat, bcnt);
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || lat != 9) begin
                n_bad++;
                $display("FAIL reset_recover: got sum=%h cout=%b ovf=%b lat=%0d, want sum=%h cout=%b ovf=%b lat=9",
                         sum, cout, ovf, lat, e.sum, e.cout, e.ovf);
            end
            $display("add 7F+01 after reset -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
        end else begin
            n_bad++;
            $display("FAIL reset_recover_done: no done within bound");
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, gap;
        bit stable;
        exp_t e;
        logic [W-1:0] first;
        @(negedge clk);
        @(negedge clk);
        a = 8'h3C; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
        sb.push_back(model(8'h3C, 8'h55, 1'b0, 1'b0));
        @(negedge clk);
        a = 8'h80; b = 8'h01; sub = 1'b1;
        sb.push_back(model(8'h80, 8'h01, 1'b0, 1'b1));
        wait_done(1, lat, bcnt);
        first = sum;
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || lat != 9) begin
                n_bad++;
                $display("FAIL b2b_first: got sum=%h cout=%b ovf=%b lat=%0d, want sum=%h cout=%b ovf=%b lat=9",
                         sum, cout, ovf, lat, e.sum, e.cout, e.ovf);
            end
            $display("b2b #1 3C+55 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
        end else begin
            n_bad++;
            $display("FAIL b2b_first_done: no done within bound");
        end
        gap = 0;
        stable = 1'b1;
        do begin
            @(negedge clk);
            gap++;
            if (done !== 1'b1 && sum !== first) stable = 1'b0;
        end while (done !== 1'b1 && gap < 40);
        start = 1'b0;
        n_cmp++;
        if (!stable || gap != 9) begin
            n_bad++;
            $display("FAIL b2b_spacing: got gap=%0d stable=%b, want gap=9 stable=1", gap, stable);
        end
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                n_bad++;
                $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            $display("b2b #2 80-01 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
        end else begin
            n_bad++;
            $display("FAIL b2b_second_done: no done within bound");
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
